// File: rtl/tpu_pkg.sv
// Shared types and helpers for the TPU activation feed path.
package tpu_pkg;

  localparam int DATA_SIZE    = 8;
  localparam int KERNEL_WIDTH = 3;

  typedef logic [DATA_SIZE-1:0] act_t;

  function automatic int num_windows(input int h, input int w, input int k);
    return (h - k + 1) * (w - k + 1);
  endfunction

endpackage

// File: rtl/tpu_line_buffer.sv
// One image row of storage: combinational read of the addressed entry, write on
// the same clock edge, so a read always returns the value from the previous row.
module tpu_line_buffer
  import tpu_pkg::*;
#(
  parameter int depth = 8,
  parameter int width = DATA_SIZE,
  localparam int AW   = (depth > 1) ? $clog2(depth) : 1
)(
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [width-1:0] i_wdata,
  output logic [width-1:0] o_rdata
);

  logic [width-1:0] r_mem [0:depth-1];

  assign o_rdata = r_mem[i_addr];

  // Row storage; contents are always rewritten before being read within a frame
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end else begin
      r_mem[i_addr] <= r_mem[i_addr];
    end
  end

endmodule

// File: rtl/tpu_window_feeder.sv
// Stride-1 im2col window generator feeding the systolic array activation bus.
// Raster pixels in, one kernelWidth x kernelWidth window per accepted pixel out.
module tpu_window_feeder
  import tpu_pkg::*;
#(
  parameter int dataSize    = DATA_SIZE,
  parameter int kernelWidth = KERNEL_WIDTH,
  parameter int imgWidth    = 8,
  parameter int imgHeight   = 8,
  localparam int nPEy       = kernelWidth * kernelWidth
)(
  input  logic                clk,
  input  logic                nrst,
  input  logic                pix_valid,
  output logic                pix_ready,
  input  logic [dataSize-1:0] pix_data,
  output logic                win_valid,
  input  logic                win_ready,
  output logic [dataSize-1:0] activation [0:nPEy-1],
  output logic                win_last
);

  localparam int CW  = (imgWidth > 1) ? $clog2(imgWidth) : 1;
  localparam int RW  = (imgHeight > 1) ? $clog2(imgHeight) : 1;
  localparam int NLB = kernelWidth - 1;

  logic [CW-1:0]       r_col_cnt;
  logic [RW-1:0]       r_row_cnt;
  logic [dataSize-1:0] r_win      [0:kernelWidth-1][0:kernelWidth-1];
  logic [dataSize-1:0] w_win_next [0:kernelWidth-1][0:kernelWidth-1];
  logic [dataSize-1:0] w_col      [0:kernelWidth-1];
  logic [dataSize-1:0] w_lb_rd    [0:NLB-1];
  logic [dataSize-1:0] w_lb_wr    [0:NLB-1];
  logic [dataSize-1:0] r_act      [0:nPEy-1];
  logic                r_win_valid;
  logic                r_win_last;
  logic                w_accept;
  logic                w_col_end;
  logic                w_row_end;
  logic                w_win_done;

  assign pix_ready  = !r_win_valid || win_ready;
  assign w_accept   = pix_valid && pix_ready;
  assign w_col_end  = (r_col_cnt == CW'(imgWidth - 1));
  assign w_row_end  = (r_row_cnt == RW'(imgHeight - 1));
  assign w_win_done = (r_col_cnt >= CW'(kernelWidth - 1)) && (r_row_cnt >= RW'(kernelWidth - 1));

  // Buffer 0 holds the previous row; each further buffer is one row older.
  genvar gk;
  generate
    for (gk = 0; gk < NLB; gk++) begin : g_lb
      if (gk == 0) begin : g_head
        assign w_lb_wr[gk] = pix_data;
      end else begin : g_chain
        assign w_lb_wr[gk] = w_lb_rd[gk-1];
      end
      tpu_line_buffer #(
        .depth (imgWidth),
        .width (dataSize)
      ) u_lb (
        .clk     (clk),
        .i_we    (w_accept),
        .i_addr  (r_col_cnt),
        .i_wdata (w_lb_wr[gk]),
        .o_rdata (w_lb_rd[gk])
      );
      assign w_col[gk] = w_lb_rd[NLB-1-gk];
    end
  endgenerate

  assign w_col[kernelWidth-1] = pix_data;

  // Window after shifting left by one column and inserting the incoming column
  always_comb begin
    for (int r = 0; r < kernelWidth; r++) begin
      for (int c = 0; c < kernelWidth - 1; c++) begin
        w_win_next[r][c] = r_win[r][c+1];
      end
      w_win_next[r][kernelWidth-1] = w_col[r];
    end
  end

  // Raster position of the next pixel to be accepted
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_col_cnt <= '0;
      r_row_cnt <= '0;
    end else if (w_accept) begin
      if (w_col_end) begin
        r_col_cnt <= '0;
        r_row_cnt <= w_row_end ? '0 : r_row_cnt + RW'(1);
      end else begin
        r_col_cnt <= r_col_cnt + CW'(1);
        r_row_cnt <= r_row_cnt;
      end
    end else begin
      r_col_cnt <= r_col_cnt;
      r_row_cnt <= r_row_cnt;
    end
  end

  // Window shift register
  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int r = 0; r < kernelWidth; r++) begin
        for (int c = 0; c < kernelWidth; c++) begin
          r_win[r][c] <= '0;
        end
      end
    end else if (w_accept) begin
      r_win <= w_win_next;
    end else begin
      r_win <= r_win;
    end
  end

  // Output register: load on a completing pixel, clear once consumed, else hold
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_win_valid <= 1'b0;
      r_win_last  <= 1'b0;
      for (int i = 0; i < nPEy; i++) begin
        r_act[i] <= '0;
      end
    end else if (w_accept && w_win_done) begin
      r_win_valid <= 1'b1;
      r_win_last  <= w_col_end && w_row_end;
      for (int r = 0; r < kernelWidth; r++) begin
        for (int c = 0; c < kernelWidth; c++) begin
          r_act[r*kernelWidth+c] <= w_win_next[r][c];
        end
      end
    end else if (pix_ready) begin
      r_win_valid <= 1'b0;
      r_win_last  <= 1'b0;
      r_act       <= r_act;
    end else begin
      r_win_valid <= r_win_valid;
      r_win_last  <= r_win_last;
      r_act       <= r_act;
    end
  end

  assign win_valid  = r_win_valid;
  assign win_last   = r_win_last;
  assign activation = r_act;

endmodule

// File: tb/tb_tpu_window_feeder.sv
// Directed and randomized checks of tpu_window_feeder against an image-array
// reference model (default 8x8 instance plus a 5x4 instance).
module tb_tpu_window_feeder;
  import tpu_pkg::*;

  localparam int IW = 8, IH = 8, K = 3, NP = K * K, WB = 8 * NP;
  localparam int SW = 5, SH = 4;
  localparam int LIMIT = 5000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nrst, pix_valid, pix_ready, win_valid, win_ready, win_last;
  act_t pix_data;
  act_t activation [0:NP-1];
  logic s_pix_valid, s_pix_ready, s_win_valid, s_win_ready, s_win_last;
  act_t s_pix_data;
  act_t s_activation [0:NP-1];

  tpu_window_feeder #(.dataSize(8), .kernelWidth(K), .imgWidth(IW), .imgHeight(IH)) dut (
    .clk(clk), .nrst(nrst), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .win_valid(win_valid), .win_ready(win_ready), .activation(activation), .win_last(win_last));

  tpu_window_feeder #(.dataSize(8), .kernelWidth(K), .imgWidth(SW), .imgHeight(SH)) dut_s (
    .clk(clk), .nrst(nrst), .pix_valid(s_pix_valid), .pix_ready(s_pix_ready), .pix_data(s_pix_data),
    .win_valid(s_win_valid), .win_ready(s_win_ready), .activation(s_activation), .win_last(s_win_last));

  typedef struct {
    logic [WB-1:0] w;
    bit            last;
  } exp_t;

  int            total = 0, bad = 0;
  exp_t          exp_q [$];
  logic [WB-1:0] win_log [$];
  logic [WB-1:0] ref_log [$];
  int            last_log [$];
  int            img [0:IH-1][0:IW-1];
  int            pidx = 0, frame_no = 0;
  bit            exp_valid = 1'b0, hold_prev = 1'b0;
  logic [WB-1:0] prev_act;
  logic          prev_last;

  task automatic check(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [WB-1:0] pack(input act_t a [0:NP-1]);
    logic [WB-1:0] v = '0;
    for (int i = 0; i < NP; i++) v = {v[WB-9:0], a[i]};
    return v;
  endfunction

  function automatic act_t pval(input int mode, input int p, input int fr);
    int r = p / IW, c = p % IW;
    case (mode)
      0:       return act_t'(8 * r + c);
      1:       return act_t'((fr % 2) * 100 + 8 * r + c);
      default: return act_t'($urandom_range(255));
    endcase
  endfunction

  task automatic clear_logs();
    win_log.delete();
    last_log.delete();
  endtask

  // Drive npix pixels; optionally keep going until every expected window is consumed.
  task automatic run(input int npix, input int mode, input int vduty, input int rduty,
                     input int stall_at, input bit drain);
    int   sent = 0, cyc = 0, stall_left = 0, r, c;
    bit   acc_done, stall_done = 1'b0;
    exp_t e;
    while ((sent < npix || (drain && exp_q.size() != 0)) && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      check("win_valid", win_valid, exp_valid);
      if (hold_prev) begin
        check("hold_act", pack(activation), prev_act);
        check("hold_last", win_last, prev_last);
      end
      pix_valid = (sent < npix) && ($urandom_range(99) < vduty);
      pix_data  = pval(mode, pidx, frame_no);
      if (sent == stall_at && !stall_done) begin
        stall_left = 5;
        stall_done = 1'b1;
      end
      win_ready = (stall_left > 0) ? 1'b0 : ($urandom_range(99) < rduty);
      #1;
      check("pix_ready", pix_ready, !win_valid || win_ready);
      if (stall_left > 0) begin
        check("stall_ready", pix_ready, 1'b0);
        stall_left--;
      end
      if (win_valid && win_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("window", pack(activation), e.w);
        check("win_last", win_last, e.last);
        win_log.push_back(pack(activation));
        if (win_last) last_log.push_back(win_log.size() - 1);
      end
      acc_done = 1'b0;
      if (pix_valid && pix_ready) begin
        r = pidx / IW;
        c = pidx % IW;
        img[r][c] = int'(pix_data);
        if (r >= K - 1 && c >= K - 1) begin
          e.w = '0;
          for (int a = 0; a < K; a++)
            for (int b = 0; b < K; b++)
              e.w = {e.w[WB-9:0], act_t'(img[r-K+1+a][c-K+1+b])};
          e.last = (r == IH - 1) && (c == IW - 1);
          exp_q.push_back(e);
          acc_done = 1'b1;
        end
        sent++;
        pidx++;
        if (pidx == IW * IH) begin
          pidx = 0;
          frame_no++;
        end
      end
      exp_valid = acc_done || (exp_valid && !win_ready);
      hold_prev = win_valid && !win_ready;
      prev_act  = pack(activation);
      prev_last = win_last;
    end
    check("run_bound", cyc < LIMIT, 1'b1);
    pix_valid = 1'b0;
  endtask

  // 5x4 instance: ramp 5r+c, always ready; expected windows derived arithmetically.
  task automatic small_test();
    int            sent = 0, nw = 0, r0, c0, nwin;
    logic [WB-1:0] got, expw, first_got = '0, last_got = '0, kfirst, klast;
    nwin = num_windows(SH, SW, K);
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (s_win_valid) begin
        got = pack(s_activation);
        r0 = nw / (SW - K + 1);
        c0 = nw % (SW - K + 1);
        expw = '0;
        for (int a = 0; a < K; a++)
          for (int b = 0; b < K; b++)
            expw = {expw[WB-9:0], act_t'(SW * (r0 + a) + c0 + b)};
        check("small_win", got, expw);
        check("small_last", s_win_last, nw == nwin - 1);
        if (nw == 0) first_got = got;
        last_got = got;
        nw++;
      end
      s_pix_valid = sent < SW * SH;
      s_pix_data  = act_t'(SW * (sent / SW) + sent % SW);
      #1;
      if (s_pix_valid && s_pix_ready) sent++;
    end
    s_pix_valid = 1'b0;
    kfirst = {8'd0, 8'd1, 8'd2, 8'd5, 8'd6, 8'd7, 8'd10, 8'd11, 8'd12};
    klast  = {8'd7, 8'd8, 8'd9, 8'd12, 8'd13, 8'd14, 8'd17, 8'd18, 8'd19};
    check("small_count", nw, 6);
    check("small_first", first_got, kfirst);
    check("small_lastwin", last_got, klast);
  endtask

  initial begin
    logic [WB-1:0] k0, k1, k35, k2f, got;
    nrst = 1'b0; pix_valid = 1'b0; pix_data = '0; win_ready = 1'b0;
    s_pix_valid = 1'b0; s_pix_data = '0; s_win_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", win_valid, 1'b0);
    check("rst_last", win_last, 1'b0);
    check("rst_act", pack(activation), '0);
    check("rst_ready", pix_ready, 1'b1);
    nrst = 1'b1;

    small_test();

    k0  = {8'd0, 8'd1, 8'd2, 8'd8, 8'd9, 8'd10, 8'd16, 8'd17, 8'd18};
    k1  = {8'd1, 8'd2, 8'd3, 8'd9, 8'd10, 8'd11, 8'd17, 8'd18, 8'd19};
    k35 = {8'd45, 8'd46, 8'd47, 8'd53, 8'd54, 8'd55, 8'd61, 8'd62, 8'd63};
    k2f = {8'd100, 8'd101, 8'd102, 8'd108, 8'd109, 8'd110, 8'd116, 8'd117, 8'd118};

    // ramp frame, always ready
    clear_logs();
    run(IW * IH, 0, 100, 100, -1, 1'b1);
    check("t1_count", win_log.size(), num_windows(IH, IW, K));
    got = (win_log.size() > 0) ? win_log[0] : '0;
    check("t1_first", got, k0);
    got = (win_log.size() > 1) ? win_log[1] : '0;
    check("t1_second", got, k1);
    got = (win_log.size() > 35) ? win_log[35] : '0;
    check("t1_lastwin", got, k35);
    check("t1_nlast", last_log.size(), 1);
    check("t1_lastidx", (last_log.size() > 0) ? last_log[0] : -1, 35);
    ref_log = win_log;

    // same frame with a 5-cycle downstream stall
    clear_logs();
    run(IW * IH, 0, 100, 100, 30, 1'b1);
    check("t2_count", win_log.size(), 36);
    for (int i = 0; i < 36; i++) begin
      got = (win_log.size() > i) ? win_log[i] : '0;
      check("t2_seq", got, ref_log[i]);
    end

    // random valid/ready duty, random pixel data
    clear_logs();
    run(IW * IH, 2, 50, 50, -1, 1'b1);
    check("t3_count", win_log.size(), 36);

    // reset after 20 pixels with a window held, then a full frame
    run(20, 0, 100, 100, -1, 1'b0);
    @(negedge clk);
    nrst = 1'b0; pix_valid = 1'b0; win_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("t4_rst_valid", win_valid, 1'b0);
    end
    nrst = 1'b1;
    exp_q.delete();
    pidx = 0; frame_no = 0; exp_valid = 1'b0; hold_prev = 1'b0;
    clear_logs();
    run(IW * IH, 0, 100, 100, -1, 1'b1);
    check("t4_count", win_log.size(), 36);
    got = (win_log.size() > 0) ? win_log[0] : '0;
    check("t4_first", got, k0);

    // two frames back to back, second offset by 100
    clear_logs();
    frame_no = 0;
    run(2 * IW * IH, 1, 100, 100, -1, 1'b1);
    check("t5_count", win_log.size(), 72);
    got = (win_log.size() > 36) ? win_log[36] : '0;
    check("t5_f2_first", got, k2f);
    check("t5_nlast", last_log.size(), 2);
    check("t5_last2", (last_log.size() > 1) ? last_log[1] : -1, 71);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tpu_window_feeder.md
Name: tpu_window_feeder

Overview:
- Sliding-window (im2col) generator directly upstream of the systolic TPU array.
- Accepts a raster-order, single-channel pixel stream and builds each kernelWidth x kernelWidth window from on-chip line buffers.
- Presents one window per cycle on the array's activation bus: nPEy = kernelWidth*kernelWidth lanes of dataSize bits.
- Stride 1, no padding, valid/ready on both sides.

Parameters:
- dataSize, 8, pixel/activation width in bits
- kernelWidth, 3, window edge; nPEy = kernelWidth*kernelWidth (localparam)
- imgWidth, 8, pixels per row (must be >= kernelWidth)
- imgHeight, 8, rows per frame (must be >= kernelWidth)

Ports:
- clk  input  1  clock
- nrst  input  1  synchronous active-low reset
- pix_valid  input  1  pixel present
- pix_ready  output  1  feeder can accept a pixel
- pix_data  input  dataSize  pixel value, raster order (row-major)
- win_valid  output  1  activation holds a complete window
- win_ready  input  1  downstream consumes the window
- activation  output  [dataSize-1:0] x [0:nPEy-1]  window; lane r*kernelWidth+c = pixel (row0+r, col0+c)
- win_last  output  1  qualifies the final window of a frame

Behaviour:
- Reset: nrst synchronous, active-low, clock clk. While nrst=0:
  - col_cnt=0, row_cnt=0.
  - win_valid=0, win_last=0, all activation lanes=0.
  - Window shift register cleared.
  - Line-buffer contents need no reset; they are never read before being written in the current frame.
- Accept rule:
  - A pixel is accepted when pix_valid && pix_ready.
  - pix_ready = !win_valid || win_ready (combinational from the output register state).
- Counters:
  - On accept, col_cnt increments.
  - At imgWidth-1, col_cnt wraps to 0 and row_cnt increments.
  - At (imgHeight-1, imgWidth-1), both counters wrap to 0, so the next pixel is (0,0) of a new frame.
- Line buffers:
  - kernelWidth-1 buffers, each imgWidth deep, addressed by col_cnt.
  - On accept, buffer k reads its entry at col_cnt and then writes buffer k-1's read value; buffer 0 writes pix_data.
  - Read-before-write within the same cycle.
- Window register:
  - kernelWidth x kernelWidth, updated only on accept.
  - Columns shift left; the new rightmost column is (oldest line buffer read, ..., buffer 0 read, pix_data), top to bottom.
  - Stale columns from the previous row after a column wrap are tolerated, because no window is emitted until col_cnt >= kernelWidth-1.
- Output:
  - Let the accepted pixel be at (r,c) with r >= kernelWidth-1 and c >= kernelWidth-1.
  - On the next cycle: win_valid=1, activation = window with bottom-right pixel (r,c).
  - Latency is 1 cycle, accept to valid.
  - win_last=1 iff (r,c) = (imgHeight-1, imgWidth-1).
- Output clearing: if the accepted pixel completes no window and the current window is consumed (or none is held), win_valid goes to 0 and win_last goes to 0.
- Hold: while win_valid && !win_ready, activation and win_last stay stable and no pixel is accepted.
- Simultaneous consume + accept: the window is replaced in the same cycle, so full throughput is one window per cycle.
- Window count: (imgHeight-kernelWidth+1)*(imgWidth-kernelWidth+1) per frame, i.e. 36 for the defaults.
- Frames back-to-back: no bubbles are required between frames.
- Reset mid-frame: the partial frame is discarded and any held window is dropped (win_valid=0). The first post-reset pixel is (0,0).
- pix_valid gaps (bubbles) do not change the output sequence.

Decomposition:
- Shared package tpu_pkg:
  - act_t (logic [dataSize-1:0]).
  - Default DATA_SIZE=8, KERNEL_WIDTH=3.
  - Function num_windows(h,w,k).
- Sub-module tpu_line_buffer:
  - Parameters depth and width.
  - Single port, read-before-write, write enable = accept.
  - Instantiated kernelWidth-1 times via generate.
- Top level holds the counters, the window shift register and the output register/handshake.

Test Plan:
- Ramp frame, pixel value = 8r+c, win_ready=1 -> first win_valid one cycle after pixel 18 is accepted, activation={0,1,2,8,9,10,16,17,18}; second window {1,2,3,9,10,11,17,18,19}; 36 windows total; last window {45,46,47,53,54,55,61,62,63} with win_last=1, the only win_last.
- Same frame, win_ready held 0 for 5 cycles mid-frame -> pix_ready=0 throughout, activation stable, sequence identical to the first test, no window lost or duplicated.
- Random pix_valid duty 50% plus random win_ready -> window sequence matches the reference model exactly, count 36.
- Reset asserted after 20 accepted pixels, then a full frame -> win_valid=0 during and after reset until pixel (2,2) of the new frame; 36 correct windows follow.
- Two frames back-to-back (second frame value = 100+8r+c) -> 72 windows; first window of frame 2 = {100,101,102,108,109,110,116,117,118}; no frame-1 data appears.
- imgWidth=5, imgHeight=4, kernelWidth=3, ramp value = 5r+c -> 6 windows; first {0,1,2,5,6,7,10,11,12}, last {7,8,9,12,13,14,17,18,19} with win_last=1.
